// File: rtl/text_console_gen.sv
// rtl/text_console_gen.sv - writable ROWS x COLS text screen rendered as 7x7 glyphs on an 8 px pitch.
// Optional cursor blink is compiled in with `define CURSOR_BLINK_EN.
module text_console_gen #(
    parameter int          COLS       = 60,
    parameter int          ROWS       = 50,
    parameter int          X0         = 80,
    parameter int          Y0         = 80,
    parameter logic [23:0] FG_RGB     = 24'h00FF00,
    parameter logic [23:0] BG_RGB     = 24'h000000,
    parameter logic [23:0] BORDER_RGB = 24'h000000,
    parameter int          BLINK_BITS = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [9:0]                x,
    input  logic [9:0]                y,
    input  logic                      frame_start,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [4:0]                wr_code,
    input  logic                      cmd_clear,
    input  logic                      cmd_home,
    output logic [$clog2(COLS)-1:0]   cursor_col,
    output logic [$clog2(ROWS)-1:0]   cursor_row,
    output logic                      busy,
    output logic [7:0]                r,
    output logic [7:0]                g,
    output logic [7:0]                b
);

    localparam int NCELLS = COLS * ROWS;
    localparam int AW     = (NCELLS > 1) ? $clog2(NCELLS) : 1;
    localparam int CW     = $clog2(COLS);
    localparam int RW     = $clog2(ROWS);
    localparam logic [10:0]   X_LO      = 11'(X0);
    localparam logic [10:0]   X_HI      = 11'(X0 + COLS * 8);
    localparam logic [10:0]   Y_LO      = 11'(Y0);
    localparam logic [10:0]   Y_HI      = 11'(Y0 + ROWS * 8);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NCELLS - 1);

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;
    logic [CW-1:0] cur_col_q, cur_col_d;
    logic [RW-1:0] cur_row_q, cur_row_d;
    logic [AW-1:0] cur_addr;
    logic          accept;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [4:0]    mem_wdata;
    logic [4:0]    mem [0:NCELLS-1];

    logic [9:0]    cx, cy;
    logic          in_area;
    logic [AW-1:0] s1_addr_q, s1_addr_d;
    logic          s1_in_q, s1_in_d;
    logic [2:0]    s1_px_q, s1_px_d;
    logic [2:0]    s1_py_q, s1_py_d;

    logic [4:0]    rd_code;
    logic [6:0]    row_bits;
    logic [7:0]    pix8;
    logic          glyph_on;
    logic          fg_sel;
    logic [23:0]   rgb_q, rgb_d;

    // Glyph rows are stored top row first; bit 6 of a row is the leftmost pixel.
    function automatic logic [6:0] glyph_row(input logic [4:0] code, input logic [2:0] row);
        logic [48:0] gl;
        logic [48:0] sh;
        case (code)
            5'd0:  gl = '0;
            5'd1:  gl = {7'b0011100, 7'b0100010, 7'b1000001, 7'b1111111, 7'b1000001, 7'b1000001, 7'b1000001};
            5'd2:  gl = {7'b1111110, 7'b1000001, 7'b1000001, 7'b1111110, 7'b1000001, 7'b1000001, 7'b1111110};
            5'd3:  gl = {7'b0111110, 7'b1000001, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000001, 7'b0111110};
            5'd4:  gl = {7'b1111100, 7'b1000010, 7'b1000001, 7'b1000001, 7'b1000001, 7'b1000010, 7'b1111100};
            5'd5:  gl = {7'b1111111, 7'b1000000, 7'b1000000, 7'b1111110, 7'b1000000, 7'b1000000, 7'b1111111};
            5'd6:  gl = {7'b1111111, 7'b1000000, 7'b1000000, 7'b1111110, 7'b1000000, 7'b1000000, 7'b1000000};
            5'd7:  gl = {7'b0111110, 7'b1000001, 7'b1000000, 7'b1001111, 7'b1000001, 7'b1000001, 7'b0111110};
            5'd8:  gl = {7'b1000001, 7'b1000001, 7'b1000001, 7'b1111111, 7'b1000001, 7'b1000001, 7'b1000001};
            5'd9:  gl = {7'b0111110, 7'b0001000, 7'b0001000, 7'b0001000, 7'b0001000, 7'b0001000, 7'b0111110};
            5'd10: gl = {7'b0011111, 7'b0000010, 7'b0000010, 7'b0000010, 7'b0000010, 7'b1000010, 7'b0111100};
            5'd11: gl = {7'b1000010, 7'b1000100, 7'b1001000, 7'b1110000, 7'b1001000, 7'b1000100, 7'b1000010};
            5'd12: gl = {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1111111};
            5'd13: gl = {7'b1000001, 7'b1100011, 7'b1010101, 7'b1001001, 7'b1000001, 7'b1000001, 7'b1000001};
            5'd14: gl = {7'b1000001, 7'b1100001, 7'b1010001, 7'b1001001, 7'b1000101, 7'b1000011, 7'b1000001};
            5'd15: gl = {7'b0111110, 7'b1000001, 7'b1000001, 7'b1000001, 7'b1000001, 7'b1000001, 7'b0111110};
            5'd16: gl = {7'b1111110, 7'b1000001, 7'b1000001, 7'b1111110, 7'b1000000, 7'b1000000, 7'b1000000};
            5'd17: gl = {7'b0111110, 7'b1000001, 7'b1000001, 7'b1000001, 7'b1000101, 7'b1000010, 7'b0111101};
            5'd18: gl = {7'b1111110, 7'b1000001, 7'b1000001, 7'b1111110, 7'b1001000, 7'b1000100, 7'b1000010};
            5'd19: gl = {7'b0111111, 7'b1000000, 7'b1000000, 7'b0111110, 7'b0000001, 7'b0000001, 7'b1111110};
            5'd20: gl = {7'b1111111, 7'b0001000, 7'b0001000, 7'b0001000, 7'b0001000, 7'b0001000, 7'b0001000};
            5'd21: gl = {7'b1000001, 7'b1000001, 7'b1000001, 7'b1000001, 7'b1000001, 7'b1000001, 7'b0111110};
            5'd22: gl = {7'b1000001, 7'b1000001, 7'b1000001, 7'b1000001, 7'b0100010, 7'b0010100, 7'b0001000};
            5'd23: gl = {7'b1000001, 7'b1000001, 7'b1000001, 7'b1001001, 7'b1010101, 7'b1100011, 7'b1000001};
            5'd24: gl = {7'b1000001, 7'b0100010, 7'b0010100, 7'b0001000, 7'b0010100, 7'b0100010, 7'b1000001};
            5'd25: gl = {7'b1000001, 7'b0100010, 7'b0010100, 7'b0001000, 7'b0001000, 7'b0001000, 7'b0001000};
            5'd26: gl = {7'b1111111, 7'b0000010, 7'b0000100, 7'b0001000, 7'b0010000, 7'b0100000, 7'b1111111};
            5'd27: gl = {7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0011000, 7'b0011000, 7'b0110000};
            5'd28: gl = {7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000, 7'b0011000, 7'b0011000};
            default: gl = '1;
        endcase
        sh = gl << (7 * row);
        return sh[48:42];
    endfunction

    assign cur_addr   = AW'(int'(cur_row_q) * COLS + int'(cur_col_q));
    assign cursor_col = cur_col_q;
    assign cursor_row = cur_row_q;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        cur_col_d  = cur_col_q;
        cur_row_d  = cur_row_q;
        mem_we     = 1'b0;
        mem_waddr  = clr_addr_q;
        mem_wdata  = 5'd0;
        accept     = 1'b0;
        wr_ready   = 1'b0;
        busy       = (state_q == ST_CLEAR);
        case (state_q)
            ST_CLEAR: begin
                mem_we = 1'b1;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = ST_IDLE;
                    clr_addr_d = '0;
                    cur_col_d  = '0;
                    cur_row_d  = '0;
                end else begin
                    clr_addr_d = clr_addr_q + AW'(1);
                end
            end
            ST_IDLE: begin
                wr_ready = !cmd_clear;
                accept   = wr_valid && wr_ready;
                if (accept) begin
                    mem_we    = 1'b1;
                    mem_waddr = cur_addr;
                    mem_wdata = wr_code;
                    if (cur_col_q == CW'(COLS - 1)) begin
                        cur_col_d = '0;
                        cur_row_d = (cur_row_q == RW'(ROWS - 1)) ? '0 : cur_row_q + RW'(1);
                    end else begin
                        cur_col_d = cur_col_q + CW'(1);
                    end
                end
                // Home wins over the advance; the write itself still used the old cursor.
                if (cmd_home) begin
                    cur_col_d = '0;
                    cur_row_d = '0;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
        if (cmd_clear) begin
            state_d    = ST_CLEAR;
            clr_addr_d = '0;
            cur_col_d  = '0;
            cur_row_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            cur_col_q  <= '0;
            cur_row_q  <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            cur_col_q  <= cur_col_d;
            cur_row_q  <= cur_row_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        cx        = x - 10'(X0);
        cy        = y - 10'(Y0);
        in_area   = ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI) &&
                    ({1'b0, y} >= Y_LO) && ({1'b0, y} < Y_HI);
        s1_addr_d = in_area ? AW'(int'(cy[9:3]) * COLS + int'(cx[9:3])) : '0;
        s1_in_d   = in_area;
        s1_px_d   = cx[2:0];
        s1_py_d   = cy[2:0];
    end

    always_comb begin
        rd_code  = mem[s1_addr_q];
        row_bits = glyph_row(rd_code, s1_py_q);
        // Column 7 maps to the appended zero, so the gap column is always off.
        pix8     = {row_bits, 1'b0};
        glyph_on = (s1_px_q != 3'd7) && (s1_py_q != 3'd7) && pix8[3'd7 - s1_px_q];
    end

`ifdef CURSOR_BLINK_EN
    logic [BLINK_BITS-1:0] blink_q, blink_d;
    logic                  s1_cur_q, s1_cur_d;

    always_comb begin
        blink_d  = frame_start ? blink_q + BLINK_BITS'(1) : blink_q;
        s1_cur_d = in_area && (CW'(cx[9:3]) == cur_col_q) && (RW'(cy[9:3]) == cur_row_q);
        fg_sel   = glyph_on ^ (s1_cur_q && blink_q[BLINK_BITS-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_q  <= '0;
            s1_cur_q <= 1'b0;
        end else begin
            blink_q  <= blink_d;
            s1_cur_q <= s1_cur_d;
        end
    end
`else
    logic unused_blink;
    assign unused_blink = frame_start & (BLINK_BITS != 0);
    assign fg_sel       = glyph_on;
`endif

    assign rgb_d = !s1_in_q ? BORDER_RGB : (fg_sel ? FG_RGB : BG_RGB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_addr_q <= '0;
            s1_in_q   <= 1'b0;
            s1_px_q   <= 3'd0;
            s1_py_q   <= 3'd0;
            rgb_q     <= 24'd0;
        end else begin
            s1_addr_q <= s1_addr_d;
            s1_in_q   <= s1_in_d;
            s1_px_q   <= s1_px_d;
            s1_py_q   <= s1_py_d;
            rgb_q     <= rgb_d;
        end
    end

    assign r = rgb_q[23:16];
    assign g = rgb_q[15:8];
    assign b = rgb_q[7:0];

endmodule

// File: tb/tb_text_console_gen.sv
// tb/tb_text_console_gen.sv - scoreboard bench for text_console_gen on a 4x2 screen.
module tb_text_console_gen;

    localparam int          COLS = 4;
    localparam int          ROWS = 2;
    localparam int          X0   = 80;
    localparam int          Y0   = 80;
    localparam logic [23:0] FG   = 24'h00FF00;
    localparam logic [23:0] BG   = 24'h102030;
    localparam logic [23:0] BD   = 24'h405060;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] x, y;
    logic       frame_start, wr_valid, wr_ready, cmd_clear, cmd_home, busy;
    logic [4:0] wr_code;
    logic [1:0] cursor_col;
    logic [0:0] cursor_row;
    logic [7:0] r, g, b;

    text_console_gen #(
        .COLS(COLS), .ROWS(ROWS), .X0(X0), .Y0(Y0),
        .FG_RGB(FG), .BG_RGB(BG), .BORDER_RGB(BD), .BLINK_BITS(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .frame_start(frame_start),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_code(wr_code),
        .cmd_clear(cmd_clear), .cmd_home(cmd_home),
        .cursor_col(cursor_col), .cursor_row(cursor_row), .busy(busy),
        .r(r), .g(g), .b(b)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [23:0] exp_q[$];
    string       name_q[$];
    logic        probe = 1'b0;
    logic        p1 = 1'b0;
    logic        p2 = 1'b0;

    always @(posedge clk) begin
        p1 <= probe;
        p2 <= p1;
    end

    always @(negedge clk) begin
        if (p2) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pixel_underflow: got %06h want <none>", {r, g, b});
            end else begin
                logic [23:0] e;
                string       nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if ({r, g, b} !== e) begin
                    errors++;
                    $display("FAIL %s: got %06h want %06h", nm, {r, g, b}, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic probe_xy(input int xx, input int yy, input logic [23:0] e, input string nm);
        x     = 10'(xx);
        y     = 10'(yy);
        probe = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        probe = 1'b0;
    endtask

    task automatic probe_cell(input int rw, input int cl, input int px, input int py,
                              input logic [23:0] e, input string nm);
        probe_xy(X0 + 8 * cl + px, Y0 + 8 * rw + py, e, nm);
    endtask

    task automatic drain();
        repeat (3) @(negedge clk);
    endtask

    // Signature pixels (0,0),(1,0),(6,0),(6,1) of a letter glyph, msb first.
    task automatic check_letter(input int rw, input int cl, input logic [3:0] sig, input string nm);
        probe_cell(rw, cl, 0, 0, sig[3] ? FG : BG, {nm, "_p00"});
        probe_cell(rw, cl, 1, 0, sig[2] ? FG : BG, {nm, "_p10"});
        probe_cell(rw, cl, 6, 0, sig[1] ? FG : BG, {nm, "_p60"});
        probe_cell(rw, cl, 6, 1, sig[0] ? FG : BG, {nm, "_p61"});
    endtask

    task automatic do_write(input logic [4:0] c);
        int n;
        n        = 0;
        wr_valid = 1'b1;
        wr_code  = c;
        while (!wr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL write_timeout: got wr_ready=0 want 1");
        end
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic count_busy(input string nm);
        int n;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (!busy) break;
        end
        chk({nm, "_busy_cycles"}, n, 8);
        chk({nm, "_ready_after"}, wr_ready, 1);
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [23:0] inv_exp;
        rst_n = 1'b0; x = '0; y = '0; frame_start = 1'b0;
        wr_valid = 1'b0; wr_code = '0; cmd_clear = 1'b0; cmd_home = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1);
        chk("rst_ready", wr_ready, 0);
        chk("rst_cursor", {cursor_row, cursor_col}, 0);
        chk("rst_rgb", {r, g, b}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midclear_rst_busy", busy, 1);
        chk("midclear_rst_rgb", {r, g, b}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        count_busy("reset");

        for (int yy = 0; yy < ROWS * 8; yy++)
            for (int xx = 0; xx < COLS * 8; xx++)
                probe_xy(X0 + xx, Y0 + yy, BG, $sformatf("blank_%0d_%0d", xx, yy));
        probe_xy(X0 - 1, Y0, BD, "border_left");
        probe_xy(X0 + COLS * 8, Y0, BD, "border_right");
        probe_xy(X0, Y0 - 1, BD, "border_top");
        probe_xy(X0, Y0 + ROWS * 8, BD, "border_bottom");
        drain();

        for (int i = 1; i <= 5; i++) do_write(5'(i));
        chk("abcde_cursor", {cursor_row, cursor_col}, {1'b1, 2'd1});
        check_letter(0, 0, 4'b0000, "cell_A");
        check_letter(0, 1, 4'b1101, "cell_B");
        check_letter(0, 2, 4'b0101, "cell_C");
        check_letter(0, 3, 4'b1100, "cell_D");
        check_letter(1, 0, 4'b1110, "cell_E");
        drain();

        for (int i = 0; i < 3; i++) do_write(5'd31);
        chk("fill_wrap_cursor", {cursor_row, cursor_col}, 0);
        do_write(5'd31);
        chk("ninth_cursor", {cursor_row, cursor_col}, {1'b0, 2'd1});
        probe_cell(0, 0, 0, 0, FG, "overwrite_00");
        probe_cell(0, 0, 6, 7, BG, "block_gap_py7");
        probe_cell(0, 0, 6, 6, FG, "block_on_66");
        probe_xy(X0 - 1, Y0 + 6, BD, "block_border");
        probe_cell(1, 3, 3, 3, FG, "block_last_cell");
        drain();

        wr_valid = 1'b1; wr_code = 5'd0; cmd_home = 1'b1;
        #1 chk("home_ready", wr_ready, 1);
        @(negedge clk);
        wr_valid = 1'b0; cmd_home = 1'b0;
        chk("home_cursor", {cursor_row, cursor_col}, 0);
        probe_cell(0, 1, 0, 0, BG, "home_write_old_pos");
        probe_cell(0, 2, 1, 0, FG, "home_cell_C_kept");
        drain();

        wr_valid = 1'b1; wr_code = 5'd31; cmd_clear = 1'b1;
        #1 chk("clear_blocks_write", wr_ready, 0);
        @(negedge clk);
        wr_valid = 1'b0; cmd_clear = 1'b0;
        chk("clear_busy", busy, 1);
        chk("clear_cursor", {cursor_row, cursor_col}, 0);
        count_busy("clear");
        for (int rw = 0; rw < ROWS; rw++)
            for (int cl = 0; cl < COLS; cl++)
                probe_cell(rw, cl, 3, 3, BG, $sformatf("cleared_%0d_%0d", rw, cl));
        probe_cell(0, 0, 0, 0, BG, "cleared_00_p00");
        drain();

`ifdef CURSOR_BLINK_EN
        inv_exp = FG;
`else
        inv_exp = BG;
`endif
        pulse_frame();
        pulse_frame();
        probe_cell(0, 0, 0, 0, inv_exp, "blink_on_cursor");
        probe_cell(0, 0, 7, 7, inv_exp, "blink_on_gap");
        probe_cell(0, 1, 0, 0, BG, "blink_other_cell");
        drain();
        pulse_frame();
        pulse_frame();
        probe_cell(0, 0, 0, 0, BG, "blink_off_cursor");
        drain();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
